// File: rtl/poly_compress_pipe.sv
`default_nettype none
// ============================================================================
// Module  : poly_compress_pipe
// Brief   : Two-stage streaming Kyber coefficient compress/decompress unit.
// Rev     : 1.0
// ============================================================================
module poly_compress_pipe #(
  parameter int D     = 1,
  parameter int LANES = 4,
  parameter int N     = 256,
  parameter int Q     = 3329
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic                  s_mode,
  input  logic [LANES*12-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [LANES*12-1:0]   m_data,
  output logic                  m_last,
  output logic                  frame_done,
  output logic                  err_range
);

  localparam int              c_beats    = N / LANES;
  localparam int              c_cw       = (c_beats > 1) ? $clog2(c_beats) : 1;
  localparam int              c_nw       = 24;
  localparam int              c_shift    = 36;
  localparam logic [63:0]     c_recip    = (64'd1 << c_shift) / 64'(Q);
  localparam logic [c_cw-1:0] c_last_cnt = c_cw'(c_beats - 1);
  localparam logic [c_nw-1:0] c_mask     = c_nw'((1 << D) - 1);
  localparam logic [0:0]      c_st_idle  = 1'b0;
  localparam logic [0:0]      c_st_run   = 1'b1;

  logic [0:0]          r_state, w_state_nxt;
  logic [c_cw-1:0]     r_beat_cnt, w_cnt_nxt;
  logic                r_mode, w_mode_nxt;
  logic                w_en, w_accept, w_first, w_beat_mode, w_beat_last, w_viol;
  logic [LANES-1:0]    w_lane_viol;
  logic [c_nw-1:0]     w_s1_n [LANES];
  logic [c_nw-1:0]     r_s1_n [LANES];
  logic                r_s1_valid, r_s1_mode, r_s1_last;
  logic [LANES*12-1:0] w_res;
  logic                r_m_valid, r_m_last, r_frame_done, r_err;
  logic [LANES*12-1:0] r_m_data;

  assign w_en       = !r_m_valid || m_ready;
  assign w_accept   = s_valid && w_en;
  assign s_ready    = w_en;
  assign m_valid    = r_m_valid;
  assign m_data     = r_m_data;
  assign m_last     = r_m_last;
  assign frame_done = r_frame_done;
  assign err_range  = r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= c_st_idle;
      r_beat_cnt <= '0;
      r_mode     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_beat_cnt <= w_cnt_nxt;
      r_mode     <= w_mode_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_beat_cnt;
    w_mode_nxt  = r_mode;
    if (w_accept) begin
      case (r_state)
        c_st_idle: begin
          w_mode_nxt = s_mode;
          if (c_beats == 1) begin
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = c_st_run;
            w_cnt_nxt   = c_cw'(1);
          end
        end
        default: begin
          if (r_beat_cnt == c_last_cnt) begin
            w_state_nxt = c_st_idle;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_beat_cnt + c_cw'(1);
          end
        end
      endcase
    end
  end

  // The first beat of a frame uses the live s_mode; later beats use the latched copy.
  always_comb begin
    w_first     = (r_state == c_st_idle);
    w_beat_mode = w_first ? s_mode : r_mode;
    w_beat_last = (r_beat_cnt == c_last_cnt);
    w_viol      = w_beat_mode && (|w_lane_viol);
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [c_nw-1:0] w_y, w_dec_n, w_cmp_n, w_n, w_q0, w_rem, w_q;
    logic [63:0]     w_prod;

    assign w_y            = c_nw'(s_data[12*i +: D]);
    assign w_dec_n        = w_y * c_nw'(Q) + c_nw'(1 << (D-1));
    assign w_cmp_n        = (c_nw'(s_data[12*i +: 12]) << D) + c_nw'(Q/2);
    assign w_s1_n[i]      = w_beat_mode ? w_cmp_n : w_dec_n;
    assign w_lane_viol[i] = (s_data[12*i +: 12] >= 12'(Q));

    // Reciprocal estimate is at most one short of n/Q; one compare fixes it up.
    assign w_n    = r_s1_n[i];
    assign w_prod = 64'(w_n) * c_recip;
    assign w_q0   = c_nw'(w_prod >> c_shift);
    assign w_rem  = w_n - w_q0 * c_nw'(Q);
    assign w_q    = (w_rem >= c_nw'(Q)) ? w_q0 + c_nw'(1) : w_q0;

    assign w_res[12*i +: 12] = r_s1_mode ? 12'(w_q & c_mask) : 12'(w_n >> D);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_mode  <= 1'b0;
      r_s1_last  <= 1'b0;
      for (int k = 0; k < LANES; k++) r_s1_n[k] <= '0;
    end else if (w_en) begin
      r_s1_valid <= s_valid;
      if (s_valid) begin
        r_s1_mode <= w_beat_mode;
        r_s1_last <= w_beat_last;
        r_s1_n    <= w_s1_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_m_data  <= '0;
    end else if (w_en) begin
      r_m_valid <= r_s1_valid;
      r_m_last  <= r_s1_valid && r_s1_last;
      if (r_s1_valid) r_m_data <= w_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_done <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_frame_done <= r_m_valid && m_ready && r_m_last;
      if (w_accept) r_err <= w_first ? w_viol : (r_err || w_viol);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_poly_compress_pipe.sv
`default_nettype none
// ============================================================================
// Module  : tb_poly_compress_pipe
// Brief   : Self-checking bench for poly_compress_pipe (D=1 main, D=10/D=4 spot).
// Rev     : 1.0
// ============================================================================
module tb_poly_compress_pipe;

  localparam int Q = 3329;

  typedef struct packed {
    logic [47:0] d;
    logic        l;
  } exp_t;

  logic        clk, rst_n;
  logic        s_valid, s_ready, s_mode, m_valid, m_ready, m_last, frame_done, err_range;
  logic [47:0] s_data, m_data;
  logic        d10_s_valid, d10_s_ready, d10_s_mode, d10_m_valid, d10_m_ready, d10_m_last, d10_fd, d10_err;
  logic [47:0] d10_s_data, d10_m_data;
  logic        d4_s_valid, d4_s_ready, d4_s_mode, d4_m_valid, d4_m_ready, d4_m_last, d4_fd, d4_err;
  logic [47:0] d4_s_data, d4_m_data;

  int   checks = 0, errors = 0, out_cnt = 0, fd_cnt = 0, tb_beat = 0;
  logic tb_mode = 1'b0;
  bit   bp_en = 1'b0;
  exp_t exp_q[$];

  poly_compress_pipe #(.D(1), .LANES(4), .N(256), .Q(Q)) u_dut (
    .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready), .s_mode(s_mode),
    .s_data(s_data), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_last(m_last), .frame_done(frame_done), .err_range(err_range));

  poly_compress_pipe #(.D(10), .LANES(4), .N(256), .Q(Q)) u_d10 (
    .clk(clk), .rst_n(rst_n), .s_valid(d10_s_valid), .s_ready(d10_s_ready), .s_mode(d10_s_mode),
    .s_data(d10_s_data), .m_valid(d10_m_valid), .m_ready(d10_m_ready), .m_data(d10_m_data),
    .m_last(d10_m_last), .frame_done(d10_fd), .err_range(d10_err));

  poly_compress_pipe #(.D(4), .LANES(4), .N(256), .Q(Q)) u_d4 (
    .clk(clk), .rst_n(rst_n), .s_valid(d4_s_valid), .s_ready(d4_s_ready), .s_mode(d4_s_mode),
    .s_data(d4_s_data), .m_valid(d4_m_valid), .m_ready(d4_m_ready), .m_data(d4_m_data),
    .m_last(d4_m_last), .frame_done(d4_fd), .err_range(d4_err));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int ref_dec(int y, int d);
    return (y * Q + 2**(d-1)) / (2**d);
  endfunction

  function automatic int ref_cmp(int x, int d);
    return ((x * 2**d + Q/2) / Q) % (2**d);
  endfunction

  function automatic logic [47:0] ref_beat(logic [47:0] din, logic mode, int d);
    logic [47:0] r;
    int lane;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      lane = int'(din[12*i +: 12]);
      if (mode) r[12*i +: 12] = 12'(ref_cmp(lane, d));
      else      r[12*i +: 12] = 12'(ref_dec(lane % (2**d), d));
    end
    return r;
  endfunction

  function automatic logic [47:0] rand_lanes(int maxv);
    logic [47:0] r;
    for (int i = 0; i < 4; i++) r[12*i +: 12] = 12'($urandom_range(maxv, 0));
    return r;
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_en) m_ready = ($urandom % 2) == 1;
    end
  end

  // Output scoreboard: in-order pop, stall stability, frame_done counting.
  initial begin
    exp_t        e;
    logic        pstall;
    logic [47:0] pd;
    logic        pl;
    pstall = 1'b0; pd = '0; pl = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pstall = 1'b0;
      end else begin
        if (pstall) begin
          checks++;
          if (m_valid !== 1'b1 || m_data !== pd || m_last !== pl) begin
            errors++;
            $display("FAIL stall_hold got v=%b d=%h l=%b exp v=1 d=%h l=%b", m_valid, m_data, m_last, pd, pl);
          end
        end
        if (m_valid && m_ready) begin
          out_cnt++;
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_beat got d=%h l=%b exp none", m_data, m_last);
          end else begin
            e = exp_q.pop_front();
            if (m_data !== e.d || m_last !== e.l) begin
              errors++;
              $display("FAIL out_beat got d=%h l=%b exp d=%h l=%b", m_data, m_last, e.d, e.l);
            end
          end
        end
        if (frame_done === 1'b1) fd_cnt++;
        pstall = m_valid && !m_ready;
        pd     = m_data;
        pl     = m_last;
      end
    end
  end

  task automatic drive_beat(input logic [47:0] data, input logic mode);
    int   n;
    exp_t e;
    s_valid = 1'b1;
    s_data  = data;
    s_mode  = mode;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!s_ready && n < 1000);
    if (!s_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout got s_ready=0 exp 1");
    end
    @(posedge clk);
    #1;
    if (tb_beat == 0) tb_mode = mode;
    e.d = ref_beat(data, tb_mode, 1);
    e.l = (tb_beat == 63);
    exp_q.push_back(e);
    tb_beat = (tb_beat + 1) % 64;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending exp 0", exp_q.size());
    end
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || frame_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl got v=%b l=%b fd=%b exp 0 0 0", m_valid, m_last, frame_done);
    end
    checks++;
    if (m_data !== 48'd0 || err_range !== 1'b0) begin
      errors++;
      $display("FAIL reset_data got d=%h err=%b exp 0 0", m_data, err_range);
    end
    checks++;
    if (s_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", s_ready);
    end
  endtask

  task automatic test_d10_d4();
    logic [47:0] a, b;
    for (int i = 0; i < 20; i++) begin
      a = (i == 0) ? {12'($urandom_range(4095, 0)), 12'd512, 12'd1, 12'd1023} : rand_lanes(4095);
      b = (i == 0) ? {12'($urandom_range(4095, 0)), 12'($urandom_range(4095, 0)), 12'd3328, 12'd1665}
                   : rand_lanes(4095);
      d10_s_valid = 1'b1; d10_s_data = a;
      d4_s_valid  = 1'b1; d4_s_data  = b;
      @(posedge clk);
      #1;
      d10_s_valid = 1'b0;
      d4_s_valid  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (d10_m_valid !== 1'b1 || d10_m_data !== ref_beat(a, 1'b0, 10)) begin
        errors++;
        $display("FAIL d10_decomp got v=%b d=%h exp v=1 d=%h", d10_m_valid, d10_m_data, ref_beat(a, 1'b0, 10));
      end
      checks++;
      if (d4_m_valid !== 1'b1 || d4_m_data !== ref_beat(b, 1'b1, 4)) begin
        errors++;
        $display("FAIL d4_comp got v=%b d=%h exp v=1 d=%h", d4_m_valid, d4_m_data, ref_beat(b, 1'b1, 4));
      end
      if (i == 0) begin
        checks++;
        if (d10_m_data[11:0] !== 12'd3326 || d10_m_data[23:12] !== 12'd3 || d10_m_data[35:24] !== 12'd1665) begin
          errors++;
          $display("FAIL d10_const got %0d %0d %0d exp 3326 3 1665",
                   d10_m_data[11:0], d10_m_data[23:12], d10_m_data[35:24]);
        end
        checks++;
        if (d4_m_data[11:0] !== 12'd8 || d4_m_data[23:12] !== 12'd0) begin
          errors++;
          $display("FAIL d4_const got %0d %0d exp 8 0", d4_m_data[11:0], d4_m_data[23:12]);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_decode();
    int o0, f0;
    o0 = out_cnt; f0 = fd_cnt;
    m_ready = 1'b1;
    drive_beat({12'd1, 12'd1, 12'd0, 12'd1}, 1'b0);
    s_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_early got m_valid=%b exp 0", m_valid);
    end
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== {12'd1665, 12'd1665, 12'd0, 12'd1665}) begin
      errors++;
      $display("FAIL decode_first got v=%b d=%h exp v=1 d=681681000681", m_valid, m_data);
    end
    @(posedge clk);
    #1;
    for (int b = 1; b < 64; b++) drive_beat(rand_lanes(4095), 1'($urandom % 2));
    s_valid = 1'b0;
    drain();
    checks++;
    if (out_cnt - o0 != 64 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL decode_frame got beats=%0d fd=%0d exp 64 1", out_cnt - o0, fd_cnt - f0);
    end
  endtask

  task automatic test_compress();
    int o0, f0, x;
    logic [47:0] d;
    o0 = out_cnt; f0 = fd_cnt;
    m_ready = 1'b1;
    drive_beat({12'd2497, 12'd2496, 12'd833, 12'd832}, 1'b1);
    s_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_valid !== 1'b1 || m_data !== {12'd0, 12'd1, 12'd1, 12'd0}) begin
      errors++;
      $display("FAIL compress_first got v=%b d=%h exp v=1 d=000001001000", m_valid, m_data);
    end
    @(posedge clk);
    #1;
    x = 0;
    for (int b = 1; b < 14 * 64; b++) begin
      for (int i = 0; i < 4; i++) begin
        d[12*i +: 12] = (x <= Q - 1) ? 12'(x) : 12'($urandom_range(Q - 1, 0));
        x++;
      end
      drive_beat(d, 1'b1);
    end
    s_valid = 1'b0;
    drain();
    checks++;
    if (out_cnt - o0 != 14 * 64 || fd_cnt - f0 != 14) begin
      errors++;
      $display("FAIL compress_sweep got beats=%0d fd=%0d exp 896 14", out_cnt - o0, fd_cnt - f0);
    end
  endtask

  task automatic test_back_to_back();
    int o0, f0;
    o0 = out_cnt; f0 = fd_cnt;
    bp_en = 1'b1;
    for (int f = 0; f < 2; f++)
      for (int b = 0; b < 64; b++)
        drive_beat(rand_lanes(Q - 1), (b == 0) ? 1'(f == 0) : 1'($urandom % 2));
    s_valid = 1'b0;
    drain();
    bp_en = 1'b0;
    m_ready = 1'b1;
    checks++;
    if (out_cnt - o0 != 128 || fd_cnt - f0 != 2) begin
      errors++;
      $display("FAIL back_to_back got beats=%0d fd=%0d exp 128 2", out_cnt - o0, fd_cnt - f0);
    end
  endtask

  task automatic test_err_range();
    logic [47:0] d;
    m_ready = 1'b1;
    for (int b = 0; b < 64; b++) begin
      d = rand_lanes(Q - 1);
      if (b == 5) d[35:24] = 12'd3500;
      drive_beat(d, 1'b1);
      if (b == 4 || b == 5 || b == 63) begin
        checks++;
        if (err_range !== (b >= 5)) begin
          errors++;
          $display("FAIL err_frame1 beat %0d got %b exp %b", b, err_range, b >= 5);
        end
      end
    end
    for (int b = 0; b < 64; b++) begin
      drive_beat(rand_lanes(Q - 1), 1'b1);
      if (b == 0) begin
        checks++;
        if (err_range !== 1'b0) begin
          errors++;
          $display("FAIL err_clear got %b exp 0", err_range);
        end
      end
    end
    s_valid = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid();
    int o0, f0;
    m_ready = 1'b1;
    for (int b = 0; b <= 20; b++) drive_beat(rand_lanes(Q - 1), 1'b0);
    rst_n   = 1'b0;
    s_valid = 1'b0;
    #1;
    checks++;
    if (m_valid !== 1'b0 || m_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid got v=%b l=%b exp 0 0", m_valid, m_last);
    end
    exp_q.delete();
    tb_beat = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    o0 = out_cnt; f0 = fd_cnt;
    for (int b = 0; b < 64; b++) drive_beat(rand_lanes(Q - 1), 1'b1);
    s_valid = 1'b0;
    drain();
    checks++;
    if (out_cnt - o0 != 64 || fd_cnt - f0 != 1) begin
      errors++;
      $display("FAIL after_reset got beats=%0d fd=%0d exp 64 1", out_cnt - o0, fd_cnt - f0);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    s_valid = 1'b0; s_mode = 1'b0; s_data = '0; m_ready = 1'b1;
    d10_s_valid = 1'b0; d10_s_mode = 1'b0; d10_s_data = '0; d10_m_ready = 1'b1;
    d4_s_valid  = 1'b0; d4_s_mode  = 1'b1; d4_s_data  = '0; d4_m_ready  = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_d10_d4();
    test_decode();
    test_compress();
    test_back_to_back();
    test_err_range();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/poly_compress_pipe.md
Name: poly_compress_pipe

Overview:
- Streaming, parametrised Kyber coefficient compression/decompression unit.
- Decompress mode maps D-bit values to 12-bit coefficients in Z_q. With D=1 this is the message-decode function: bit 1 -> 1665, bit 0 -> 0.
- Compress mode maps 12-bit coefficients to D-bit values. This serves message encode (D=1) and ciphertext u/v compression (D=10/4 for K=2,3; D=11/5 for K=4).
- Processes LANES coefficients per beat over a frame of N coefficients, with a valid/ready handshake on both sides. Sits between the polynomial arithmetic datapath and the byte (de)serialiser.

Parameters:
- D, 1, compression width in bits. Legal range 1..11.
- LANES, 4, coefficients per beat. Must divide N.
- N, 256, coefficients per polynomial frame.
- Q, 3329, modulus.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- s_valid  in  1  input beat valid.
- s_ready  out  1  input beat accepted when s_valid && s_ready.
- s_mode  in  1  0 = decompress, 1 = compress. Sampled only on the first beat of a frame.
- s_data  in  LANES*12  lane i at [12*i +: 12]. Decompress uses the low D bits of each lane and ignores the upper bits.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream ready.
- m_data  out  LANES*12  lane i at [12*i +: 12]. Compress output uses the low D bits; upper bits are 0.
- m_last  out  1  marks the final beat of a frame (beat N/LANES-1).
- frame_done  out  1  one-cycle pulse when the m_last beat is accepted.
- err_range  out  1  sticky. Set when a compress-mode input lane is >= Q.

Behaviour:
- Reset (async, rst_n=0) clears: m_valid=0, m_data=0, m_last=0, frame_done=0, err_range=0. Beat counter=0, FSM=IDLE, latched mode=0, and all pipeline-stage valids=0.
- s_ready is combinational: s_ready = !m_valid || m_ready. Pipeline enable en = s_ready; when en=0 all stages hold. No ready-to-valid combinational path except through this term.
- Latency: 2 cycles from input acceptance to m_valid with no stall.
  - Stage 1: multiply and add the rounding constant.
  - Stage 2: shift/divide, reduce, and register output.
- Throughput: 1 beat/cycle.
- Decompress, per lane: y = s_data lane[D-1:0]; out = (y*Q + 2^(D-1)) >> D. Result is always in 0..Q-1 and is written zero-extended to 12 bits.
- Compress, per lane: x = lane[11:0]; out = floor((x*2^D + floor(Q/2)) / Q) mod 2^D. Division is by constant Q; the implementation technique is free (reciprocal multiply allowed) but must be bit-exact for all x in 0..4095.
  - The mod 2^D wrap is required: for x near Q the rounded result 2^D wraps to 0.
  - If x >= Q, compute with the same formula and set err_range.
- Intermediate widths must be sized so that no overflow occurs for D=11 and x=4095.
- FSM (input side):
  - IDLE: on the first accepted beat, latch s_mode, set beat_cnt=1, clear err_range, and go to RUN. If N/LANES==1, stay in IDLE with beat_cnt=0.
  - RUN: each accepted beat increments beat_cnt. When the beat with beat_cnt==N/LANES-1 is accepted, beat_cnt wraps to 0 and the FSM returns to IDLE.
- Mode changes on s_mode mid-frame are ignored. The latched mode travels with each beat through the pipeline, so back-to-back frames with different modes are handled without bubbles.
- m_last is carried through the pipeline alongside the beat and asserts exactly on output beat N/LANES-1.
- frame_done = m_valid && m_ready && m_last, registered, so it pulses the cycle after the handshake.
- err_range is clear-on-new-frame: it clears on the first accepted beat of the next frame. If that first beat also violates, err_range stays 1.
- Stall: while m_valid && !m_ready, m_data, m_last and m_valid hold stable.
- Reset asserted mid-frame: the in-flight frame is discarded immediately; after release the next accepted beat is treated as beat 0.

Test Plan:
- D=1, decompress, lanes {1,0,1,1} -> m_data lanes {1665,0,1665,1665} 2 cycles after acceptance; 64 beats, m_last only on beat 63, frame_done pulse once.
- D=1, compress, lanes {832,833,2496,2497} -> {0,1,1,0}. Sweep all x in 0..3328 against the reference formula.
- D=10, decompress y=1023 -> 3326; y=1 -> 3; y=512 -> 1665. D=4, compress x=1665 -> 8; x=3328 -> 0 (wrap).
- Random m_ready backpressure (about 50%), two back-to-back frames with s_mode toggling on a non-first beat -> outputs unchanged by the mid-frame toggle, data order preserved, no dropped or duplicated beats.
- Compress with x=3500 in frame 1 -> err_range=1 held for the rest of frame 1; clean frame 2 -> err_range clears on its first accepted beat.
- rst_n pulsed low on beat 20 -> m_valid=0 immediately; the next frame's m_last lands on its own beat 63.
